// File: rtl/latch_cmd_gen.sv
// Start/stop command generator for a downstream SR latch.
// It synchronizes and debounces the buttons and adds a door interlock that forces R.
module latch_cmd_gen #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_btn,
    input  logic stop_btn,
    input  logic door_open,
    output logic S,
    output logic R,
    output logic run
);

    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    // Index 0 is the start button and index 1 is the stop button.
    logic [1:0]       btn_sync1_r;
    logic [1:0]       btn_sync2_r;
    logic [1:0]       db_r;
    logic [1:0]       db_d_r;
    logic [CNT_W-1:0] cnt_r [2];
    logic             door_sync1_r;
    logic             door_sync2_r;
    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic             s_nxt_s;
    logic             r_nxt_s;
    logic             start_ev_s;
    logic             stop_ev_s;

    // Two-flop synchronizers for all three raw inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync1_r  <= 2'b00;
            btn_sync2_r  <= 2'b00;
            door_sync1_r <= 1'b0;
            door_sync2_r <= 1'b0;
        end else begin
            btn_sync1_r  <= {stop_btn, start_btn};
            btn_sync2_r  <= btn_sync1_r;
            door_sync1_r <= door_open;
            door_sync2_r <= door_sync1_r;
        end
    end

    // Debounce counters and levels; db_d_r keeps the previous level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r   <= 2'b00;
            db_d_r <= 2'b00;
            cnt_r  <= '{default: '0};
        end else begin
            db_d_r <= db_r;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    db_r[i]  <= btn_sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    assign start_ev_s = db_r[0] & ~db_d_r[0];
    assign stop_ev_s  = db_r[1] & ~db_d_r[1];

    // Next-state and command decode: stop and door take priority over start
    always_comb begin
        state_nxt_s = state_r;
        s_nxt_s     = 1'b0;
        r_nxt_s     = door_sync2_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ev_s && !stop_ev_s && !door_sync2_r) begin
                    state_nxt_s = ST_RUN;
                    s_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_ev_s || door_sync2_r) begin
                    state_nxt_s = ST_IDLE;
                    r_nxt_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered latch commands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            run     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            S       <= s_nxt_s;
            R       <= r_nxt_s;
            run     <= (state_nxt_s == ST_RUN);
        end
    end

endmodule

// File: tb/tb_latch_cmd_gen.sv
// Scoreboard bench for latch_cmd_gen. Each S/R pulse the stimulus expects is queued
// with its cycle number, and a monitor checks each pulse the DUT drives against that queue.
module tb_latch_cmd_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_btn = 1'b0;
    logic stop_btn = 1'b0;
    logic door_open = 1'b0;
    logic S;
    logic R;
    logic run;

    typedef struct {
        logic s;
        logic r;
        int   cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    latch_cmd_gen #(.DB_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .stop_btn(stop_btn),
        .door_open(door_open), .S(S), .R(R), .run(run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with S or R high must match the oldest expected pulse
    always @(negedge clk) begin
        if (rst_n && (S || R)) begin
            n_vec = n_vec + 1;
            if (exp_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_pulse cyc=%0d got S=%b R=%b, required no pulse", cyc, S, R);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (S !== e.s || R !== e.r || cyc != e.cyc) begin
                    n_err = n_err + 1;
                    $display("FAIL pulse got S=%b R=%b at cyc %0d, required S=%b R=%b at cyc %0d",
                             S, R, cyc, e.s, e.r, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic s, input logic r, input int c);
        exp_t e;
        e.s = s; e.r = r; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_run(input string name, input logic req);
        n_vec = n_vec + 1;
        if (run !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s run=%b required %b", name, run, req);
        end
    endtask

    // Press a button before the next edge k=cyc+1, then expect the command after edge k+6.
    task automatic press_start_expect_s;
        start_btn = 1'b1;
        expect_pulse(1'b1, 1'b0, cyc + 7);
        tick(7);
        check_run("start_run", 1'b1);
        tick(10);
        start_btn = 1'b0;
        tick(10);
    endtask

    initial begin
        int n;
        tick(2);
        #1;
        n_vec = n_vec + 1;
        if (S !== 1'b0 || R !== 1'b0 || run !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL reset_state S=%b R=%b run=%b required 0 0 0", S, R, run);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Glitch of 2 cycles is filtered
        start_btn = 1'b1;
        tick(2);
        start_btn = 1'b0;
        tick(12);
        check_run("glitch", 1'b0);

        // Start press, one S while held
        press_start_expect_s();
        check_run("start_held", 1'b1);

        // Stop in RUN
        n = cyc;
        stop_btn = 1'b1;
        expect_pulse(1'b0, 1'b1, n + 7);
        tick(6);
        check_run("stop_before", 1'b1);
        tick(1);
        check_run("stop_after", 1'b0);
        tick(4);
        stop_btn = 1'b0;
        tick(10);

        // Second start gives a new S
        press_start_expect_s();

        // Door interlock for 8 cycles: R from edge k+2 for as long as door is synchronized high
        n = cyc;
        door_open = 1'b1;
        for (int i = 3; i <= 10; i++) expect_pulse(1'b0, 1'b1, n + i);
        tick(1);
        start_btn = 1'b1;
        tick(2);
        check_run("door_run", 1'b0);
        tick(5);
        door_open = 1'b0;
        tick(6);
        start_btn = 1'b0;
        tick(12);
        check_run("door_start_ignored", 1'b0);

        // Simultaneous start and stop in IDLE
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        tick(12);
        check_run("simul_idle", 1'b0);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        tick(10);

        // Simultaneous start and stop in RUN
        press_start_expect_s();
        n = cyc;
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        expect_pulse(1'b0, 1'b1, n + 7);
        tick(8);
        check_run("simul_run", 1'b0);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        tick(10);

        // Reset mid-run clears outputs immediately, no S after release
        press_start_expect_s();
        #2;
        rst_n = 1'b0;
        #1;
        n_vec = n_vec + 1;
        if (S !== 1'b0 || R !== 1'b0 || run !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL reset_mid_run S=%b R=%b run=%b required 0 0 0", S, R, run);
        end
        tick(2);
        rst_n = 1'b1;
        tick(15);
        check_run("after_reset", 1'b0);

        n_vec = n_vec + 1;
        if (exp_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL missing_pulses got %0d pending, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/latch_cmd_gen.md
LATCH_CMD_GEN -- requirements
Module: latch_cmd_gen

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive clock edges a synchronized button level must differ from its debounced level before the debounced level updates (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, meaning the debounce counter width (must hold DB_CYCLES).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start_btn, input, 1 bit: raw asynchronous start button, active-high.
REQ-006 SHALL have port stop_btn, input, 1 bit: raw asynchronous stop button, active-high.
REQ-007 SHALL have port door_open, input, 1 bit: raw asynchronous door switch, active-high; synchronized only, not debounced.
REQ-008 SHALL have port S, output, 1 bit: registered set command to the downstream SR latch.
REQ-009 SHALL have port R, output, 1 bit: registered reset command to the downstream SR latch.
REQ-010 SHALL have port run, output, 1 bit: registered mirror of the commanded latch state (1 = RUN).

Function
REQ-011 SHALL pass start_btn, stop_btn and door_open each through a two-flop synchronizer.
REQ-012 SHALL debounce start and stop independently: the counter clears on any edge where the synchronized level equals the debounced level; it increments otherwise; on the DB_CYCLES-th consecutive differing edge the debounced level takes the synchronized value and the counter clears.
REQ-013 SHALL treat a glitch shorter than DB_CYCLES synchronized cycles as filtered, with no change to the debounced level.
REQ-014 SHALL derive start_ev and stop_ev as single-cycle events on the rising edge of the respective debounced level; falling edges produce no event.
REQ-015 SHALL implement a two-state FSM: IDLE and RUN.
REQ-016 IDLE -> RUN when start_ev=1, stop_ev=0 and synchronized door_open=0; S SHALL be 1 for exactly the following cycle.
REQ-017 RUN -> IDLE when stop_ev=1 or synchronized door_open=1; R SHALL be 1 for exactly the following cycle.
REQ-018 start_ev in RUN and stop_ev in IDLE SHALL be ignored, producing no pulse.
REQ-019 SHALL give stop priority: start_ev and stop_ev in the same cycle yield no S; in RUN they yield R.
REQ-020 SHALL hold R=1 on every cycle in which synchronized door_open=1, regardless of state, and SHALL suppress S while door_open is synchronized high.
REQ-021 S and R SHALL never both be 1 in the same cycle.
REQ-022 Latency: a raw start_btn rise held stable before edge k SHALL produce S=1 in the cycle after edge k+DB_CYCLES+2 (edge k+6 for the default). Stop latency is identical. door_open latency is 3 edges to R.
REQ-023 run SHALL equal 1 exactly while the FSM is in RUN, updating on the same edge S or R asserts.
REQ-024 A start button held continuously SHALL generate only one S; a new S requires release (debounced low) and re-press.

Reset
REQ-025 While rst_n=0, all synchronizers, debounced levels (0), counters (0), FSM (IDLE), S, R and run SHALL be 0 immediately, independent of clk.
REQ-026 Deassertion of rst_n mid-debounce or mid-pulse SHALL discard the pending event; a button already held at release SHALL produce one start_ev after DB_CYCLES+2 edges.

Verification
REQ-027 Start press: rst_n high, door_open=0, start_btn 0->1 before edge 10, held -> S=1 only in cycle after edge 16, run=1 from edge 16, R=0 throughout.
REQ-028 Glitch: start_btn high for 2 clock cycles only -> S stays 0, run stays 0.
REQ-029 Stop in RUN: from run=1, stop_btn press held 10 cycles -> single R pulse 6 edges after the press, run=0 on the same edge; a second start press -> new S.
REQ-030 Door interlock: run=1, door_open=1 for 8 cycles -> R=1 from edge 3 for as long as door_open stays synchronized high, run=0; a start press during that time -> S stays 0.
REQ-031 Simultaneous: start_btn and stop_btn rise on the same cycle in IDLE -> S=0, R=0, run=0. Repeated in RUN -> one R, run=0.
REQ-032 Reset mid-run: run=1, rst_n pulsed low between edges -> S, R and run are 0 immediately. With no button held after release, no S follows.
